// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button levels into run/clear/lap
// strobes, a display freeze window and the lap-select index.
module stopwatch_ctrl #(
  parameter int unsigned NUM_LAPS    = 5,
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       btn_recall,
  output logic       run_en,
  output logic       clear,
  output logic       lap_store,
  output logic       freeze,
  output logic [2:0] disp_sel,
  output logic [2:0] lap_count,
  output logic [1:0] state_dbg
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [2:0] MaxLaps = 3'(NUM_LAPS);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StLap   = 2'd2,
    StPause = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       lap_count_q, lap_count_d;
  logic [2:0]       disp_sel_q, disp_sel_d;
  logic             clear_q, clear_d;
  logic             lap_store_q, lap_store_d;
  logic             ss_prev_q, lr_prev_q, rc_prev_q;

  logic       ss_press, lr_press, rc_press;
  logic [2:0] sel_next, lap_inc;

  always_comb begin
    ss_press = btn_start_stop & ~ss_prev_q;
    lr_press = btn_lap_reset & ~lr_prev_q;
    rc_press = btn_recall & ~rc_prev_q;

    // Recall walks 0..lap_count and wraps back to live time.
    if (lap_count_q == 3'd0 || disp_sel_q >= lap_count_q) begin
      sel_next = 3'd0;
    end else begin
      sel_next = disp_sel_q + 3'd1;
    end
    lap_inc = (lap_count_q < MaxLaps) ? lap_count_q + 3'd1 : lap_count_q;

    state_d     = state_q;
    hold_d      = hold_q;
    lap_count_d = lap_count_q;
    disp_sel_d  = disp_sel_q;
    clear_d     = 1'b0;
    lap_store_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ss_press) begin
          state_d    = StRun;
          disp_sel_d = 3'd0;
        end else if (lr_press) begin
          clear_d     = 1'b1;
          lap_count_d = 3'd0;
          disp_sel_d  = 3'd0;
        end else if (rc_press) begin
          disp_sel_d = sel_next;
        end
      end
      StRun: begin
        if (ss_press) begin
          state_d = StPause;
        end else if (lr_press) begin
          lap_store_d = 1'b1;
          lap_count_d = lap_inc;
          hold_d      = HoldLoad;
          state_d     = StLap;
        end
      end
      StLap: begin
        if (ss_press) begin
          state_d = StPause;
        end else if (lr_press) begin
          lap_store_d = 1'b1;
          lap_count_d = lap_inc;
          hold_d      = HoldLoad;
        end else if (hold_q == '0) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      StPause: begin
        if (ss_press) begin
          state_d    = StRun;
          disp_sel_d = 3'd0;
        end else if (lr_press) begin
          clear_d     = 1'b1;
          lap_count_d = 3'd0;
          disp_sel_d  = 3'd0;
          state_d     = StIdle;
        end else if (rc_press) begin
          disp_sel_d = sel_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      lap_count_q <= 3'd0;
      disp_sel_q  <= 3'd0;
      clear_q     <= 1'b1;
      lap_store_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      lap_count_q <= lap_count_d;
      disp_sel_q  <= disp_sel_d;
      clear_q     <= clear_d;
      lap_store_q <= lap_store_d;
    end
    // Loaded during reset too, so a button held through reset is not a press.
    ss_prev_q <= btn_start_stop;
    lr_prev_q <= btn_lap_reset;
    rc_prev_q <= btn_recall;
  end

  assign run_en    = (state_q == StRun) || (state_q == StLap);
  assign freeze    = (state_q == StLap);
  assign clear     = clear_q;
  assign lap_store = lap_store_q;
  assign disp_sel  = disp_sel_q;
  assign lap_count = lap_count_q;
  assign state_dbg = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch datapath. It turns three debounced push-button levels into the control signals the datapath needs:
- a run enable for the time counter;
- a one-cycle clear strobe;
- a one-cycle lap-capture strobe for the lap shift storage;
- a display-freeze flag;
- the lap-select index for the display mux.

It sits between the debouncers and the counter / lap storage / display path, and replaces direct wiring of switches to those blocks.

## Interface
- NUM_LAPS, 5, number of stored lap slots; disp_sel range is 0..NUM_LAPS.
- HOLD_CYCLES, 100_000_000, cycles the display stays frozen after a lap capture (2 s at 50 MHz); must be ≥ 1.

- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- btn_start_stop  in  1  debounced level, 1 = pressed.
- btn_lap_reset  in  1  debounced level, 1 = pressed.
- btn_recall  in  1  debounced level, 1 = pressed.
- run_en  out  1  counter enable.
- clear  out  1  one-cycle clear strobe to the counter and lap storage.
- lap_store  out  1  one-cycle strobe; storage shifts the current time in.
- freeze  out  1  display holds the last captured lap.
- disp_sel  out  3  0 = live time, k = k-th most recent lap.
- lap_count  out  3  number of valid laps, saturating at NUM_LAPS.
- state_dbg  out  2  current state encoding.

## Operation
- One clock (clk). Reset is synchronous and active-high.
- All three button inputs are synchronous to clk and already debounced.
- Each button has a previous-value register. A press is `btn & ~btn_prev`. Holding a button produces exactly one press.
- States and encoding: IDLE=0, RUN=1, LAP=2, PAUSE=3.
- Priority when presses coincide in one cycle: start_stop > lap_reset > recall. Lower-priority presses in that cycle are discarded, not queued.

Transitions and actions:
- **IDLE**
  - start_stop → RUN.
  - lap_reset → clear pulse, stay in IDLE.
  - recall → advance disp_sel.
- **RUN**
  - start_stop → PAUSE.
  - lap_reset → lap_store pulse, lap_count += 1 (saturating), load hold counter with HOLD_CYCLES-1, → LAP.
  - recall → ignored.
- **LAP**
  - start_stop → PAUSE; freeze drops.
  - lap_reset → lap_store pulse, lap_count += 1 (saturating), reload hold counter, stay in LAP.
  - Otherwise, hold counter == 0 → RUN; else decrement the hold counter.
  - recall → ignored.
- **PAUSE**
  - start_stop → RUN; disp_sel forced to 0.
  - lap_reset → clear pulse, lap_count = 0, disp_sel = 0, → IDLE.
  - recall → advance disp_sel.

Output rules:
- Advancing disp_sel: 0→1→…→lap_count→0. If lap_count = 0, disp_sel stays 0.
- run_en = 1 exactly in RUN and LAP.
- freeze = 1 exactly in LAP.
- disp_sel = 0 in RUN and LAP.
- At saturation (lap_count = NUM_LAPS), lap_store still pulses. The oldest lap is dropped by storage; lap_count stays at NUM_LAPS.
- The hold counter width is $clog2(HOLD_CYCLES) bits, minimum 1.

## Timing
- All outputs are registered.
- A press sampled at edge k (btn = 1 at edge k, btn_prev = 0) produces its state and output change visible immediately after edge k.
- Press-to-output latency is 1 cycle from the input transition.
- clear and lap_store are high for exactly one cycle per accepted press.
- freeze is high for exactly HOLD_CYCLES cycles after a lap press, unless a start_stop press cuts it short.
- Each further lap press during LAP restarts the full HOLD_CYCLES window.
- Reset, when sampled high:
  - state = IDLE, run_en = 0, lap_store = 0, freeze = 0, disp_sel = 0, lap_count = 0, hold counter = 0.
  - clear = 1 for every cycle reset is high; clear drops on the first edge with reset low.
  - Button prev registers load the current button levels, so a button held through reset does not produce a press.
- Reset mid-LAP or mid-RUN aborts immediately, with no lap_store pulse.

## Test plan
- **Start/stop/clear:** reset, then press start_stop.
  - run_en = 1 one cycle later.
  - Second press → PAUSE, run_en = 0.
  - lap_reset press → clear = 1 for one cycle, state = IDLE, lap_count = 0.
- **Lap hold (HOLD_CYCLES = 4):** in RUN, press lap_reset.
  - lap_store one cycle, freeze = 1 for exactly 4 cycles, run_en = 1 throughout, then state = RUN.
  - A second lap press on hold cycle 3 → freeze extended to 4 cycles from that press, lap_count = 2.
- **Saturation:** 7 lap presses in RUN with NUM_LAPS = 5.
  - 7 lap_store pulses; lap_count = 1, 2, 3, 4, 5, 5, 5.
- **Recall:** lap_count = 3, in PAUSE, press recall 5 times.
  - disp_sel = 1, 2, 3, 0, 1.
  - start_stop press → disp_sel = 0, run_en = 1.
  - Recall with lap_count = 0 keeps disp_sel = 0.
- **Simultaneous and held presses:** start_stop and lap_reset pressed in the same cycle in RUN → PAUSE with no lap_store. start_stop held for 100 cycles → one transition only.
- **Reset mid-operation:** reset asserted in LAP with a button held high.
  - All outputs take their reset values and clear = 1 while reset is high.
  - No press is detected after release until the held button goes low and high again.
